// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-stage PC sequencer.
// Sequencer state encodings, default reset/exception addresses, instruction-word shift.
// Imported by pc_sequencer; holds no logic.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BUBBLE = 2'd2
  } seqState_t;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0080;

  // Branch offsets are in instruction words; shift converts words to bytes.
  localparam int INSTR_SHIFT = 2;

  // Bubble counter covers 0..7 bubbles.
  localparam int BUB_W = 3;

endpackage

// File: rtl/incrementer_n.sv
// Combinational adder: {carry, sum} = dataIn + STEP, modulo 2**WIDTH with carry out.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input continuously.
module incrementer_n #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, dataIn} + (WIDTH+1)'(STEP);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: sequential advance, prioritised redirects, post-redirect bubbles.
// Latency: 1 cycle from accept/redirect to new pc; pc_plus is combinational from pc only.
// Backpressure: pc advances only when pc_valid & pc_ready & ~stall; redirects override stall.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               STEP       = 4,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEFAULT_RESET_PC),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEFAULT_EXC_VECTOR),
  parameter int               BUBBLES    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_ready,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic             jump_en,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             exc_en,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             pc_valid,
  output logic             wrapped,
  output logic             misaligned
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);
  localparam logic [BUB_W-1:0] BUB_INIT   = BUB_W'(BUBBLES);

  seqState_t        stateQ, stateD;
  logic [BUB_W-1:0] bubCntQ, bubCntD;
  logic [WIDTH-1:0] pcQ, pcD, pcPlus, branchTarget, redirectTarget;
  logic             incCarry, redirect, accept, pcValid;
  logic             wrappedQ, misalignedQ;

  incrementer_n #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_inc (
    .dataIn (pcQ),
    .sum    (pcPlus),
    .carry  (incCarry)
  );

  // pc_valid is a pure function of registered state, so no input reaches it combinationally.
  assign pcValid      = (stateQ == ST_RUN);
  assign redirect     = (stateQ != ST_BOOT) & (exc_en | jump_en | branch_taken);
  assign accept       = pcValid & pc_ready & ~stall;
  assign branchTarget = pcPlus + (branch_offset << INSTR_SHIFT);

  // Redirect target selection: exception beats jump beats branch.
  always_comb begin
    redirectTarget = branchTarget;
    if (exc_en) begin
      redirectTarget = EXC_VECTOR;
    end else if (jump_en) begin
      redirectTarget = jump_target;
    end
  end

  // Next PC: a redirect wins over a sequential advance; otherwise hold.
  always_comb begin
    pcD = pcQ;
    if (redirect) begin
      pcD = redirectTarget;
    end else if (accept) begin
      pcD = pcPlus;
    end
  end

  // Next state and bubble count; stall freezes the countdown unless a redirect restarts it.
  always_comb begin
    stateD  = stateQ;
    bubCntD = bubCntQ;
    case (stateQ)
      ST_BOOT: begin
        stateD = ST_RUN;
      end
      ST_RUN: begin
        if (redirect && (BUBBLES > 0)) begin
          stateD  = ST_BUBBLE;
          bubCntD = BUB_INIT;
        end
      end
      ST_BUBBLE: begin
        if (redirect) begin
          bubCntD = BUB_INIT;
        end else if (!stall) begin
          if (bubCntQ <= BUB_W'(1)) begin
            stateD  = ST_RUN;
            bubCntD = '0;
          end else begin
            bubCntD = bubCntQ - BUB_W'(1);
          end
        end
      end
      default: begin
        stateD  = ST_BOOT;
        bubCntD = '0;
      end
    endcase
  end

  // State, PC and status flags; misaligned is sticky between redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ      <= ST_BOOT;
      bubCntQ     <= '0;
      pcQ         <= RESET_PC;
      wrappedQ    <= 1'b0;
      misalignedQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      bubCntQ  <= bubCntD;
      pcQ      <= pcD;
      wrappedQ <= accept & ~redirect & incCarry;
      if (redirect) begin
        misalignedQ <= |(redirectTarget & ALIGN_MASK);
      end
    end
  end

  assign pc         = pcQ;
  assign pc_plus    = pcPlus;
  assign pc_valid   = pcValid;
  assign wrapped    = wrappedQ;
  assign misaligned = misalignedQ;

endmodule
